reset_sequencer: RTL and testbench

RESET_SEQUENCER -- requirements
Module: reset_sequencer

---
 rtl/reset_sequencer.sv | 166 ++++++++++++++++
 tb/tb_reset_sequencer.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/reset_sequencer.sv
// Releases p_num_stages reset domains one at a time, each gated by its ack.
// Latency: outputs are registered from the FSM state, one edge after the decision edge; i_reset acts on the same edge.
// Backpressure: none. A missing or dropped ack parks all domains in reset until i_reset or i_sw_reset_req.
module reset_sequencer #(
    parameter int p_num_stages  = 3,
    parameter int p_hold_cycles = 4,
    parameter int p_gap_cycles  = 2,
    parameter int p_ack_timeout = 8,
    localparam int lp_idx_w     = (p_num_stages > 1) ? $clog2(p_num_stages) : 1
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_sw_reset_req,
    input  logic [p_num_stages-1:0] i_stage_ack,
    output logic [p_num_stages-1:0] o_stage_reset,
    output logic                    o_done,
    output logic                    o_error,
    output logic [lp_idx_w-1:0]     o_err_stage
);

    localparam int lp_cnt_max_hg = (p_hold_cycles > p_gap_cycles) ? p_hold_cycles : p_gap_cycles;
    localparam int lp_cnt_max    = (lp_cnt_max_hg > p_ack_timeout) ? lp_cnt_max_hg : p_ack_timeout;
    localparam int lp_cnt_w      = $clog2(lp_cnt_max + 1);

    localparam logic [lp_idx_w-1:0] lp_last_stage = lp_idx_w'(p_num_stages - 1);
    localparam logic [lp_cnt_w-1:0] lp_hold_end   = lp_cnt_w'(p_hold_cycles - 1);
    localparam logic [lp_cnt_w-1:0] lp_gap_end    = lp_cnt_w'(p_gap_cycles - 1);
    localparam logic [lp_cnt_w-1:0] lp_ack_end    = lp_cnt_w'(p_ack_timeout);

    typedef enum logic [2:0] {
        ST_HOLD,
        ST_RELEASE_WAIT,
        ST_GAP,
        ST_DONE,
        ST_ERROR
    } state_t;

    state_t                    state_q, state_d;
    logic [lp_idx_w-1:0]       k_q, k_d;
    logic [lp_cnt_w-1:0]       cnt_q, cnt_d;
    logic [lp_idx_w-1:0]       err_k_q, err_k_d;
    logic [lp_idx_w-1:0]       lowest_drop;
    logic [p_num_stages-1:0]   stage_reset_d;

    // Scan downward so the last assignment wins with the lowest dropped index.
    always_comb begin
        lowest_drop = '0;
        for (int i = p_num_stages - 1; i >= 0; i--) begin
            if (!i_stage_ack[i]) begin
                lowest_drop = lp_idx_w'(i);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        cnt_d   = cnt_q;
        err_k_d = err_k_q;

        if (i_sw_reset_req) begin
            state_d = ST_HOLD;
            k_d     = '0;
            cnt_d   = '0;
            err_k_d = '0;
        end else begin
            case (state_q)
                ST_HOLD: begin
                    if (cnt_q == lp_hold_end) begin
                        state_d = ST_RELEASE_WAIT;
                        k_d     = '0;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end

                // The ack is honoured on the final window edge before timing out.
                ST_RELEASE_WAIT: begin
                    if (i_stage_ack[k_q]) begin
                        cnt_d = '0;
                        if (k_q == lp_last_stage) begin
                            state_d = ST_DONE;
                        end else if (p_gap_cycles == 0) begin
                            state_d = ST_RELEASE_WAIT;
                            k_d     = k_q + 1'b1;
                        end else begin
                            state_d = ST_GAP;
                        end
                    end else if (cnt_q == lp_ack_end) begin
                        state_d = ST_ERROR;
                        err_k_d = k_q;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end

                ST_GAP: begin
                    if (cnt_q == lp_gap_end) begin
                        state_d = ST_RELEASE_WAIT;
                        k_d     = k_q + 1'b1;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end

                ST_DONE: begin
                    if (!(&i_stage_ack)) begin
                        state_d = ST_ERROR;
                        err_k_d = lowest_drop;
                    end
                end

                ST_ERROR: begin
                    state_d = ST_ERROR;
                end

                default: begin
                    state_d = ST_HOLD;
                    k_d     = '0;
                    cnt_d   = '0;
                    err_k_d = '0;
                end
            endcase
        end
    end

    // Stages 0..k are out of reset while sequencing, which keeps the pattern a thermometer.
    always_comb begin
        stage_reset_d = '1;
        case (state_q)
            ST_RELEASE_WAIT, ST_GAP: begin
                for (int i = 0; i < p_num_stages; i++) begin
                    stage_reset_d[i] = (i > int'(k_q));
                end
            end
            ST_DONE: stage_reset_d = '0;
            default: stage_reset_d = '1;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q       <= ST_HOLD;
            k_q           <= '0;
            cnt_q         <= '0;
            err_k_q       <= '0;
            o_stage_reset <= '1;
            o_done        <= 1'b0;
            o_error       <= 1'b0;
            o_err_stage   <= '0;
        end else begin
            state_q       <= state_d;
            k_q           <= k_d;
            cnt_q         <= cnt_d;
            err_k_q       <= err_k_d;
            o_stage_reset <= stage_reset_d;
            o_done        <= (state_q == ST_DONE);
            o_error       <= (state_q == ST_ERROR);
            o_err_stage   <= (state_q == ST_ERROR) ? err_k_q : '0;
        end
    end

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer (3 stages, hold 4, gap 2, timeout 8).
// Scenario edges are relative to a base so that i_reset is first sampled low at edge 10.
module tb_reset_sequencer;

    localparam int N = 3;

    logic         i_clk = 1'b0;
    logic         i_reset;
    logic         i_sw_reset_req;
    logic [N-1:0] i_stage_ack;
    logic [N-1:0] o_stage_reset;
    logic         o_done;
    logic         o_error;
    logic [1:0]   o_err_stage;

    int edge_n   = 0;
    int base     = 0;
    int n_checks = 0;
    int n_errors = 0;

    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) edge_n <= edge_n + 1;

    reset_sequencer #(
        .p_num_stages (N),
        .p_hold_cycles(4),
        .p_gap_cycles (2),
        .p_ack_timeout(8)
    ) dut (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .i_sw_reset_req(i_sw_reset_req),
        .i_stage_ack   (i_stage_ack),
        .o_stage_reset (o_stage_reset),
        .o_done        (o_done),
        .o_error       (o_error),
        .o_err_stage   (o_err_stage)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic [N-1:0] rst, input logic done,
                              input logic err, input logic [1:0] es);
        check({tag, ".stage_reset"}, 32'(o_stage_reset), 32'(rst));
        check({tag, ".done"},        32'(o_done),        32'(done));
        check({tag, ".error"},       32'(o_error),       32'(err));
        check({tag, ".err_stage"},   32'(o_err_stage),   32'(es));
    endtask

    // Returns at the falling edge after scenario edge e, so outputs of edge e are visible
    // and anything driven now is sampled at edge e+1.
    task automatic at_edge(input int e);
        while (edge_n < base + e) @(negedge i_clk);
    endtask

    task automatic restart(input logic [N-1:0] ack);
        int tgt;
        i_reset        = 1'b1;
        i_sw_reset_req = 1'b0;
        i_stage_ack    = ack;
        tgt = edge_n + 1;
        while (edge_n < tgt) @(negedge i_clk);
        expect_out("reset_edge", 3'b111, 1'b0, 1'b0, 2'd0);
        tgt = edge_n + 1;
        while (edge_n < tgt) @(negedge i_clk);
        base    = edge_n - 9;
        i_reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        i_reset        = 1'b1;
        i_sw_reset_req = 1'b0;
        i_stage_ack    = '1;

        // Acks tied high: full sequence, then drop ack[2] and ack[0] together, then sw restart.
        restart(3'b111);
        at_edge(9);  expect_out("A9",  3'b111, 1'b0, 1'b0, 2'd0);
        at_edge(13); expect_out("A13", 3'b111, 1'b0, 1'b0, 2'd0);
        at_edge(14); expect_out("A14", 3'b110, 1'b0, 1'b0, 2'd0);
        at_edge(16); expect_out("A16", 3'b110, 1'b0, 1'b0, 2'd0);
        at_edge(17); expect_out("A17", 3'b100, 1'b0, 1'b0, 2'd0);
        at_edge(19); expect_out("A19", 3'b100, 1'b0, 1'b0, 2'd0);
        at_edge(20); expect_out("A20", 3'b000, 1'b0, 1'b0, 2'd0);
        at_edge(21); expect_out("A21", 3'b000, 1'b1, 1'b0, 2'd0);
        at_edge(25); i_stage_ack = 3'b010;
        at_edge(26); expect_out("A26", 3'b000, 1'b1, 1'b0, 2'd0);
        at_edge(27); expect_out("A27", 3'b111, 1'b0, 1'b1, 2'd0);
        at_edge(30); expect_out("A30", 3'b111, 1'b0, 1'b1, 2'd0);
        at_edge(39); i_sw_reset_req = 1'b1; i_stage_ack = 3'b111;
        at_edge(40); expect_out("A40", 3'b111, 1'b0, 1'b1, 2'd0); i_sw_reset_req = 1'b0;
        at_edge(41); expect_out("A41", 3'b111, 1'b0, 1'b0, 2'd0);
        at_edge(44); expect_out("A44", 3'b111, 1'b0, 1'b0, 2'd0);
        at_edge(45); expect_out("A45", 3'b110, 1'b0, 1'b0, 2'd0);
        at_edge(48); expect_out("A48", 3'b100, 1'b0, 1'b0, 2'd0);

        // ack[1] never arrives: timeout after the last window edge, error persists.
        restart(3'b101);
        at_edge(17); expect_out("B17", 3'b100, 1'b0, 1'b0, 2'd0);
        at_edge(25); expect_out("B25", 3'b100, 1'b0, 1'b0, 2'd0);
        at_edge(26); expect_out("B26", 3'b111, 1'b0, 1'b1, 2'd1);
        at_edge(35); expect_out("B35", 3'b111, 1'b0, 1'b1, 2'd1);

        // ack[1] on the last allowed edge, then ack[2] dropped alone in DONE.
        restart(3'b101);
        at_edge(24); i_stage_ack = 3'b111;
        at_edge(25); expect_out("C25", 3'b100, 1'b0, 1'b0, 2'd0);
        at_edge(26); expect_out("C26", 3'b100, 1'b0, 1'b0, 2'd0);
        at_edge(27); expect_out("C27", 3'b100, 1'b0, 1'b0, 2'd0);
        at_edge(28); expect_out("C28", 3'b000, 1'b0, 1'b0, 2'd0);
        at_edge(29); expect_out("C29", 3'b000, 1'b1, 1'b0, 2'd0);
        at_edge(30); i_stage_ack = 3'b011;
        at_edge(31); expect_out("C31", 3'b000, 1'b1, 1'b0, 2'd0);
        at_edge(32); expect_out("C32", 3'b111, 1'b0, 1'b1, 2'd2);

        // i_reset and i_sw_reset_req together mid-sequence: reset wins on that edge.
        restart(3'b111);
        at_edge(17); expect_out("D17", 3'b100, 1'b0, 1'b0, 2'd0);
        at_edge(18); i_reset = 1'b1; i_sw_reset_req = 1'b1;
        at_edge(19); expect_out("D19", 3'b111, 1'b0, 1'b0, 2'd0);
        i_reset = 1'b0; i_sw_reset_req = 1'b0;
        at_edge(21); expect_out("D21", 3'b111, 1'b0, 1'b0, 2'd0);
        at_edge(23); expect_out("D23", 3'b111, 1'b0, 1'b0, 2'd0);
        at_edge(24); expect_out("D24", 3'b110, 1'b0, 1'b0, 2'd0);

        // sw request during HOLD restarts the hold count.
        restart(3'b111);
        at_edge(11); i_sw_reset_req = 1'b1;
        at_edge(12); i_sw_reset_req = 1'b0;
        at_edge(14); expect_out("E14", 3'b111, 1'b0, 1'b0, 2'd0);
        at_edge(16); expect_out("E16", 3'b111, 1'b0, 1'b0, 2'd0);
        at_edge(17); expect_out("E17", 3'b110, 1'b0, 1'b0, 2'd0);
        at_edge(20); expect_out("E20", 3'b100, 1'b0, 1'b0, 2'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
